shift_register_controller: RTL

Sequencer for the 8-bit rotating shift register built from shift_flipflop cells. It accepts one command at a time over a valid/ready handshake: parallel load, rotate right, rotate left, or arithmetic shift right by N. It drives the register's parallel_loadn, load_left, asr and D bus for the required number of cycles. The register cells have no enable, so the controller also holds the register in idle by reloading its own Q.

---
 rtl/shift_ctrl_pkg.sv | 22 ++
 rtl/shift_count_down.sv | 35 +++
 rtl/shift_register_controller.sv | 107 ++++++++++
 3 files changed

// File: rtl/shift_ctrl_pkg.sv
// Shared definitions for the shift register controller: op codes, FSM states,
// default geometry.
package shift_ctrl_pkg;

  localparam int unsigned WIDTH_DEF = 8;
  localparam int unsigned CNT_W_DEF = 3;

  typedef enum logic [1:0] {
    OP_LOAD = 2'b00,
    OP_ROR  = 2'b01,
    OP_ROL  = 2'b10,
    OP_ASR  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_DONE
  } state_e;

endpackage

// File: rtl/shift_count_down.sv
// Loadable down-counter; tc flags the last remaining shift (count == 1).
module shift_count_down #(
  parameter int unsigned CNT_W = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             tc
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/shift_register_controller.sv
// Command sequencer for the rotating shift register; holds the register in idle
// by reloading its own Q, since the cells have no enable.
module shift_register_controller
  import shift_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_amount,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [WIDTH-1:0] q_in,
  output logic             parallel_loadn,
  output logic             load_left,
  output logic             asr,
  output logic [WIDTH-1:0] d_out,
  output logic             busy,
  output logic             done
);

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             cnt_load;
  logic             cnt_dec;
  logic             cnt_tc;

  shift_count_down #(
    .CNT_W (CNT_W)
  ) u_count (
    .clock    (clock),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (cmd_amount),
    .dec      (cnt_dec),
    .tc       (cnt_tc)
  );

  always_comb begin
    state_d        = state_q;
    op_d           = op_q;
    data_d         = data_q;
    cnt_load       = 1'b0;
    cnt_dec        = 1'b0;
    cmd_ready      = 1'b0;
    busy           = 1'b1;
    done           = 1'b0;
    parallel_loadn = 1'b0;
    load_left      = 1'b0;
    asr            = 1'b0;
    d_out          = q_in;

    unique case (state_q)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid) begin
          op_d     = op_e'(cmd_op);
          data_d   = cmd_data;
          cnt_load = 1'b1;
          if (op_e'(cmd_op) == OP_LOAD) begin
            state_d = ST_LOAD;
          end else if (cmd_amount != '0) begin
            state_d = ST_SHIFT;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_LOAD: begin
        d_out   = data_q;
        state_d = ST_DONE;
      end
      ST_SHIFT: begin
        parallel_loadn = 1'b1;
        load_left      = (op_q != OP_ROL);
        asr            = (op_q == OP_ASR);
        cnt_dec        = 1'b1;
        if (cnt_tc) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      op_q    <= OP_LOAD;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      data_q  <= data_d;
    end
  end

endmodule
